// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage load/store unit. Accepts one aligned load or store from the
//   pipeline, runs a single valid/ready bus transaction, stalls the pipeline
//   while the bus is busy, and returns an extended load result.
//   Misaligned requests are rejected in the request cycle with MisalignM.
//   A transaction that sees no bus_ready for TIMEOUT cycles is aborted
//   with BusErrM.
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   MemReadM, MemWriteM           load / store request (both high = store)
//   LoadTypeM  [2:0]              000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
//   StoreTypeM [1:0]              00 SW, 01 SH, 10 SB
//   ALUResultM [31:0]             byte address
//   WriteDataM [31:0]             store data, right-aligned
//   ReadDataM  [31:0]             extended load result (valid in DONE)
//   StallM                        freeze pipeline at and upstream of Memory
//   MisalignM, BusErrM            one-cycle exception pulses
//   bus_*                         word-addressed valid/ready memory bus
//
// state | meaning
// IDLE  | waiting for a request; accepts aligned requests combinationally
// REQ   | bus_valid high, waiting for bus_ready or timeout
// DONE  | result/exception presented for one cycle, pipeline released
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  LoadTypeM,
  input  logic [1:0]  StoreTypeM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsuState;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsuState     state, nextState;

  logic        reqValid;
  logic        reqAligned;
  logic        accept;
  logic        cntLast;

  logic [31:0] addrQ;
  logic        isStoreQ;
  logic [2:0]  loadTypeQ;
  logic [1:0]  storeTypeQ;
  logic [31:0] wdataQ;
  logic [31:0] rdataQ;
  logic        errQ;
  logic [7:0]  cnt;

  logic [31:0] loadResult;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  assign reqValid = MemReadM | MemWriteM;

  // A simultaneous read and write is a store, so alignment follows StoreTypeM.
  always_comb begin
    reqAligned = 1'b0;
    if (MemWriteM) begin
      case (StoreTypeM)
        2'b01:   reqAligned = ~ALUResultM[0];
        2'b10:   reqAligned = 1'b1;
        default: reqAligned = (ALUResultM[1:0] == 2'b00);
      endcase
    end else begin
      case (LoadTypeM)
        3'b001, 3'b010: reqAligned = ~ALUResultM[0];
        3'b011, 3'b100: reqAligned = 1'b1;
        default:        reqAligned = (ALUResultM[1:0] == 2'b00);
      endcase
    end
  end

  // rst gates the combinational outputs so nothing escapes while held in reset.
  assign accept  = rst & (state == IDLE) & reqValid & reqAligned;
  assign cntLast = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state logic; a handshake on the last counted cycle wins over timeout.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = REQ;
      REQ:     if (bus_ready || cntLast) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request latch, timeout counter and read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addrQ      <= '0;
      isStoreQ   <= 1'b0;
      loadTypeQ  <= '0;
      storeTypeQ <= '0;
      wdataQ     <= '0;
      rdataQ     <= '0;
      errQ       <= 1'b0;
      cnt        <= '0;
    end else begin
      if (accept) begin
        addrQ      <= ALUResultM;
        isStoreQ   <= MemWriteM;
        loadTypeQ  <= LoadTypeM;
        storeTypeQ <= StoreTypeM;
        wdataQ     <= WriteDataM;
        errQ       <= 1'b0;
        cnt        <= '0;
      end
      if (state == REQ) begin
        if (bus_ready) begin
          if (!isStoreQ) rdataQ <= bus_rdata;
        end else if (cntLast) begin
          errQ <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  // Lane selection and extension of the captured word
  always_comb begin
    case (addrQ[1:0])
      2'b00:   loadByte = rdataQ[7:0];
      2'b01:   loadByte = rdataQ[15:8];
      2'b10:   loadByte = rdataQ[23:16];
      default: loadByte = rdataQ[31:24];
    endcase
    loadHalf = addrQ[1] ? rdataQ[31:16] : rdataQ[15:0];
    case (loadTypeQ)
      3'b001:  loadResult = {{16{loadHalf[15]}}, loadHalf};
      3'b010:  loadResult = {16'h0000, loadHalf};
      3'b011:  loadResult = {{24{loadByte[7]}}, loadByte};
      3'b100:  loadResult = {24'h000000, loadByte};
      default: loadResult = rdataQ;
    endcase
  end

  // Outputs
  always_comb begin
    ReadDataM = '0;
    StallM    = 1'b0;
    MisalignM = 1'b0;
    BusErrM   = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wstrb = '0;
    bus_wdata = '0;
    case (state)
      IDLE: begin
        StallM    = accept;
        MisalignM = rst & reqValid & ~reqAligned;
      end
      REQ: begin
        StallM    = 1'b1;
        bus_valid = 1'b1;
        bus_addr  = {addrQ[31:2], 2'b00};
        bus_we    = isStoreQ;
        if (isStoreQ) begin
          case (storeTypeQ)
            2'b01: begin
              bus_wstrb = addrQ[1] ? 4'b1100 : 4'b0011;
              bus_wdata = {2{wdataQ[15:0]}};
            end
            2'b10: begin
              bus_wstrb = 4'b0001 << addrQ[1:0];
              bus_wdata = {4{wdataQ[7:0]}};
            end
            default: begin
              bus_wstrb = 4'b1111;
              bus_wdata = wdataQ;
            end
          endcase
        end
      end
      DONE: begin
        BusErrM = errQ;
        if (!errQ && !isStoreQ) ReadDataM = loadResult;
      end
      default: ;
    endcase
  end

endmodule
